// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: rotate-left, rotate-right, bounce and blink modes.
// Start/stop, pause/resume and mode-advance pulses drive an IDLE/RUN/PAUSE
// FSM; a prescaler derives the pattern step rate from clk.
module led_seq_ctrl #(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 25000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_p,
  input  logic             pause_p,
  input  logic             mode_p,
  output logic [WIDTH-1:0] led,
  output logic [1:0]       mode,
  output logic             busy,
  output logic             step
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t           state_reg, state_next;
  logic [PW-1:0]    presc_reg, presc_next;
  logic [WIDTH-1:0] led_reg, led_next;
  logic [1:0]       mode_reg, mode_next;
  logic             dir_reg, dir_next;    // 0 = moving left, 1 = moving right
  logic             step_reg, step_next;
  logic             busy_reg, busy_next;

  // Starting pattern of each mode.
  function automatic logic [WIDTH-1:0] init_pattern(input logic [1:0] m);
    logic [WIDTH-1:0] p;
    p = '0;
    case (m)
      2'd1:    p[WIDTH-1] = 1'b1;
      2'd3:    p = '1;
      default: p[0] = 1'b1;
    endcase
    return p;
  endfunction

  // State and output registers; reset takes effect without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      presc_reg <= '0;
      led_reg   <= '0;
      mode_reg  <= 2'd0;
      dir_reg   <= 1'b0;
      step_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      presc_reg <= presc_next;
      led_reg   <= led_next;
      mode_reg  <= mode_next;
      dir_reg   <= dir_next;
      step_reg  <= step_next;
      busy_reg  <= busy_next;
    end
  end

  // Next-state logic: pulse priority start > pause > mode, ticks only when no pulse acts.
  always_comb begin
    state_next = state_reg;
    presc_next = presc_reg;
    led_next   = led_reg;
    mode_next  = mode_reg;
    dir_next   = dir_reg;
    step_next  = 1'b0;

    if (start_p) begin
      presc_next = '0;
      dir_next   = 1'b0;
      if (state_reg == IDLE) begin
        state_next = RUN;
        led_next   = init_pattern(mode_reg);
      end else begin
        state_next = IDLE;
        led_next   = '0;
      end
    end else if (pause_p) begin
      // In IDLE the pulse is ignored but still masks a simultaneous mode_p.
      if (state_reg == RUN) begin
        state_next = PAUSE;
      end else if (state_reg == PAUSE) begin
        state_next = RUN;
      end
    end else if (mode_p) begin
      mode_next = mode_reg + 2'd1;
      if (state_reg != IDLE) begin
        led_next   = init_pattern(mode_reg + 2'd1);
        presc_next = '0;
        dir_next   = 1'b0;
      end
    end else if (state_reg == RUN) begin
      if (presc_reg == PRESC_MAX) begin
        presc_next = '0;
        step_next  = 1'b1;
        case (mode_reg)
          2'd0: led_next = {led_reg[WIDTH-2:0], led_reg[WIDTH-1]};
          2'd1: led_next = {led_reg[0], led_reg[WIDTH-1:1]};
          2'd2: begin
            if (!dir_reg) begin
              if (led_reg[WIDTH-1]) begin
                dir_next = 1'b1;
                led_next = led_reg >> 1;
              end else begin
                led_next = led_reg << 1;
              end
            end else begin
              if (led_reg[0]) begin
                dir_next = 1'b0;
                led_next = led_reg << 1;
              end else begin
                led_next = led_reg >> 1;
              end
            end
          end
          default: led_next = ~led_reg;
        endcase
      end else begin
        presc_next = presc_reg + 1'b1;
      end
    end

    busy_next = (state_next != IDLE);
  end

  assign led  = led_reg;
  assign mode = mode_reg;
  assign busy = busy_reg;
  assign step = step_reg;

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, LED bus width (min 2).
REQ-002 SHALL have parameter TICK_DIV, default 25000000, clk cycles per pattern step (min 2).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start_p  input  1  single-cycle pulse from a one-shot: start when idle, stop when active.
REQ-006 SHALL have port pause_p  input  1  single-cycle pulse: pause or resume.
REQ-007 SHALL have port mode_p  input  1  single-cycle pulse: advance pattern mode.
REQ-008 SHALL have port led  output  WIDTH  LED drive, registered.
REQ-009 SHALL have port mode  output  2  current pattern mode, registered.
REQ-010 SHALL have port busy  output  1  high when state is RUN or PAUSE, registered.
REQ-011 SHALL have port step  output  1  one-cycle pulse coincident with each led pattern update from a tick, registered.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, PAUSE.
REQ-013 SHALL: IDLE + start_p -> RUN; load led with mode's initial pattern; clear prescaler.
REQ-014 SHALL: RUN or PAUSE + start_p -> IDLE; led = 0; prescaler cleared.
REQ-015 SHALL: RUN + pause_p -> PAUSE; PAUSE + pause_p -> RUN; pause_p in IDLE ignored.
REQ-016 SHALL: mode_p in any state sets mode = (mode+1) mod 4, wrapping 3 -> 0.
REQ-017 SHALL: mode_p in RUN or PAUSE also reloads led with the new mode's initial pattern, clears prescaler, sets bounce direction left; state unchanged.
REQ-018 SHALL prioritise simultaneous pulses start_p > pause_p > mode_p; lower-priority pulses ignored that cycle.
REQ-019 SHALL run prescaler 0..TICK_DIV-1 only in RUN; hold in PAUSE; clear in IDLE.
REQ-020 SHALL generate internal tick when prescaler == TICK_DIV-1 in RUN; prescaler wraps to 0 the same edge.
REQ-021 SHALL update led on tick only; step asserted the cycle after that edge, for exactly one cycle.
REQ-022 SHALL not tick in a cycle where start_p, pause_p or mode_p is acted upon.
REQ-023 SHALL implement mode 0 rotate-left: initial 1 at bit 0; per tick, led rotated left by 1 (bit WIDTH-1 -> bit 0).
REQ-024 SHALL implement mode 1 rotate-right: initial 1 at bit WIDTH-1; per tick, led rotated right by 1 (bit 0 -> bit WIDTH-1).
REQ-025 SHALL implement mode 2 bounce: initial 1 at bit 0, direction left; per tick, shift in the current direction; when the lit bit is at WIDTH-1 (moving left) or at 0 (moving right), reverse direction and shift the opposite way on the same tick.
REQ-026 SHALL implement mode 3 blink: initial all ones; per tick, led inverted.
REQ-027 SHALL hold led, mode and direction unchanged while in PAUSE.
REQ-028 SHALL never show more than one lit bit in modes 0-2.

Reset
REQ-029 SHALL, while rst high, force state IDLE, led 0, mode 0, busy 0, step 0, prescaler 0, direction left, independent of clk.
REQ-030 SHALL, on rst mid-RUN or mid-PAUSE, discard pattern and mode; the first start_p after release begins mode 0 from its initial pattern.
REQ-031 SHALL treat pulses arriving while rst is high as lost.

Verification (WIDTH=8, TICK_DIV=4)
REQ-032 SHALL cover: reset, start_p in mode 0 -> led 0x01, busy 1; after 4 cycles 0x02, step pulse; after 32 cycles total back to 0x01.
REQ-033 SHALL cover: mode 2 running from 0x01 -> steps 0x02 .. 0x80, then 0x40, and after 14 ticks total back to 0x01, then 0x02.
REQ-034 SHALL cover: RUN at 0x04, pause_p -> led frozen 0x04 for 20 cycles, no step; pause_p -> next step after exactly 4 more prescaler counts from the held value.
REQ-035 SHALL cover: start_p and pause_p in the same cycle while RUN -> IDLE, led 0x00, busy 0; mode_p four times while IDLE -> mode 0, led stays 0x00.
REQ-036 SHALL cover: mode 3 running, tick sequence 0xFF, 0x00, 0xFF; mode_p -> mode 0, led 0x01, prescaler cleared.
REQ-037 SHALL cover: rst asserted asynchronously mid-RUN in mode 1 between clk edges -> led 0x00, mode 0, busy 0 before the next clk edge.
